mainfsm_ws: RTL and testbench

// - Next-generation main control FSM for the multicycle ARM core; drives the same datapath controls as the current FSM.
// - Adds a MemReady wait-state handshake on every memory state and a per-access timeout with a sticky fault.
// - Adds a configurable trap for undefined Op encodings and an optional multi-cycle multiply path.
// - Sits in the controller beside the decoder and cond logic; Branch/RegW/MemW/NextPC feed the cond-gating unit unchanged.

---
 rtl/mainfsm_pkg.sv | 56 +++++
 rtl/mainfsm_wait_timer.sv | 31 +++
 rtl/mainfsm_ws.sv | 149 ++++++++++++++
 tb/tb_mainfsm_ws.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mainfsm_pkg.sv
// Shared types and control-word constants for the main control FSM.
// Control word: {NextPC,Branch,MemW,RegW,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}.
package mainfsm_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_EXECM  = 4'd10,
      S_FAULT  = 4'd15
   } state_t;

   localparam logic [1:0] FC_NONE    = 2'b00;
   localparam logic [1:0] FC_TIMEOUT = 2'b01;
   localparam logic [1:0] FC_ILLEGAL = 2'b10;

   localparam int CTRL_W = 12;

   localparam logic [CTRL_W-1:0] CW_FETCH  = 12'b1_0_0_0_1_0_10_1_10_0;
   localparam logic [CTRL_W-1:0] CW_DECODE = 12'b0_0_0_0_0_0_10_1_10_0;
   localparam logic [CTRL_W-1:0] CW_MEMADR = 12'b0_0_0_0_0_0_10_0_01_0;
   localparam logic [CTRL_W-1:0] CW_MEMRD  = 12'b0_0_0_0_0_1_00_0_01_0;
   localparam logic [CTRL_W-1:0] CW_MEMWB  = 12'b0_0_0_1_0_1_01_0_01_0;
   localparam logic [CTRL_W-1:0] CW_MEMWR  = 12'b0_0_1_0_0_1_00_0_01_0;
   localparam logic [CTRL_W-1:0] CW_EXECR  = 12'b0_0_0_0_0_0_10_0_00_1;
   localparam logic [CTRL_W-1:0] CW_EXECI  = 12'b0_0_0_0_0_0_10_0_01_1;
   localparam logic [CTRL_W-1:0] CW_ALUWB  = 12'b0_0_0_1_0_0_00_0_01_0;
   localparam logic [CTRL_W-1:0] CW_BRANCH = 12'b0_1_0_0_0_0_10_0_01_0;
   localparam logic [CTRL_W-1:0] CW_IDLE   = CW_DECODE;

   function automatic logic [CTRL_W-1:0] ctrl_of(input state_t s);
      logic [CTRL_W-1:0] c;
      case (s)
         S_FETCH:  c = CW_FETCH;
         S_DECODE: c = CW_DECODE;
         S_MEMADR: c = CW_MEMADR;
         S_MEMRD:  c = CW_MEMRD;
         S_MEMWB:  c = CW_MEMWB;
         S_MEMWR:  c = CW_MEMWR;
         S_EXECR:  c = CW_EXECR;
         S_EXECI:  c = CW_EXECI;
         S_ALUWB:  c = CW_ALUWB;
         S_BRANCH: c = CW_BRANCH;
         default:  c = CW_IDLE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mainfsm_wait_timer.sv
// Wait-state counter for memory states; expire flags WAIT_TIMEOUT waits.
// WAIT_TIMEOUT=0 disables expiry entirely.
module mainfsm_wait_timer #(
   parameter int WAIT_TIMEOUT = 16,
   parameter int TO_W = $clog2(WAIT_TIMEOUT + 2)
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic inc,
   output logic expire
);

   localparam logic [TO_W-1:0] LIMIT = TO_W'(WAIT_TIMEOUT);

   logic [TO_W-1:0] cnt;

   // Saturates at LIMIT so it cannot wrap while the FSM sits in a wait state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != LIMIT)) begin
         cnt <= cnt + TO_W'(1);
      end
   end

   assign expire = (WAIT_TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/mainfsm_ws.sv
// Multicycle main control FSM with MemReady wait states, timeout and fault trap.
// Define MAINFSM_MUL_EN to enable the multi-cycle multiply path (EXECM).
module mainfsm_ws
   import mainfsm_pkg::*;
#(
   parameter int WAIT_TIMEOUT = 16,
   parameter int TO_W = $clog2(WAIT_TIMEOUT + 2),
   parameter int ILLEGAL_TRAP = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic       IsMul,
   input  logic       MemReady,
   input  logic       MulDone,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic       NextPC,
   output logic       RegW,
   output logic       MemW,
   output logic       Branch,
   output logic       ALUOp,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       MemReq,
   output logic       MulStart,
   output logic       Fault,
   output logic [1:0] FaultCode,
   output logic [3:0] StateOut
);

   state_t state, next;
   logic [1:0] code_nx;
   logic wait_st, expire, en_ok;
   logic [CTRL_W-1:0] ctrl;
   logic unused_ok;

   assign wait_st = (state == S_FETCH) || (state == S_MEMRD) ||
                    (state == S_MEMWR);

   mainfsm_wait_timer #(
      .WAIT_TIMEOUT(WAIT_TIMEOUT),
      .TO_W(TO_W)
   ) u_timer (
      .clk(clk),
      .reset_n(reset_n),
      .clr(MemReady || (next != state)),
      .inc(wait_st && !MemReady),
      .expire(expire)
   );

   always_comb begin
      next = state;
      code_nx = FC_NONE;
      case (state)
         S_FETCH:
            if (MemReady) next = S_DECODE;
            else if (expire) begin
               next = S_FAULT;
               code_nx = FC_TIMEOUT;
            end
         S_MEMRD:
            if (MemReady) next = S_MEMWB;
            else if (expire) begin
               next = S_FAULT;
               code_nx = FC_TIMEOUT;
            end
         S_MEMWR:
            if (MemReady) next = S_FETCH;
            else if (expire) begin
               next = S_FAULT;
               code_nx = FC_TIMEOUT;
            end
         S_DECODE:
            case (Op)
               2'b00:
                  if (Funct[5]) next = S_EXECI;
`ifdef MAINFSM_MUL_EN
                  else if (IsMul) next = S_EXECM;
`endif
                  else next = S_EXECR;
               2'b01: next = S_MEMADR;
               2'b10: next = S_BRANCH;
               default:
                  if (ILLEGAL_TRAP != 0) begin
                     next = S_FAULT;
                     code_nx = FC_ILLEGAL;
                  end else begin
                     next = S_FETCH;
                  end
            endcase
         S_MEMADR: next = Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMWB:  next = S_FETCH;
         S_EXECR:  next = S_ALUWB;
         S_EXECI:  next = S_ALUWB;
         S_ALUWB:  next = S_FETCH;
         S_BRANCH: next = S_FETCH;
`ifdef MAINFSM_MUL_EN
         S_EXECM:  if (MulDone) next = S_ALUWB;
`endif
         S_FAULT:  next = S_FAULT;
         default:  next = S_FETCH;
      endcase
   end

`ifdef MAINFSM_MUL_EN
   logic mul_seen;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_FETCH;
         Fault <= 1'b0;
         FaultCode <= FC_NONE;
`ifdef MAINFSM_MUL_EN
         mul_seen <= 1'b0;
`endif
      end else begin
         state <= next;
         if ((next == S_FAULT) && (state != S_FAULT)) begin
            Fault <= 1'b1;
            FaultCode <= code_nx;
         end
`ifdef MAINFSM_MUL_EN
         mul_seen <= (state == S_EXECM);
`endif
      end
   end

`ifdef MAINFSM_MUL_EN
   assign MulStart = reset_n && (state == S_EXECM) && !mul_seen;
   assign unused_ok = ^Funct[4:1];
`else
   assign MulStart = 1'b0;
   assign unused_ok = ^{Funct[4:1], IsMul, MulDone};
`endif

   // Reset gating drops strobes without waiting for the state register
   assign en_ok = reset_n && (!wait_st || MemReady);
   assign ctrl = ctrl_of(state);

   assign {NextPC, Branch, MemW, RegW, IRWrite} = ctrl[11:7] & {5{en_ok}};
   assign {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp} = ctrl[6:0];
   assign MemReq = reset_n && wait_st;
   assign StateOut = state;

endmodule

// File: tb/tb_mainfsm_ws.sv
// Scoreboard bench for mainfsm_ws: timing, wait states, timeout, traps, reset.
// Main instance uses WAIT_TIMEOUT=4; a legacy instance checks ILLEGAL_TRAP=0.
module tb_mainfsm_ws;

   logic clk = 1'b0;
   logic reset_n;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic IsMul, MemReady, MulDone;

   logic IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp;
   logic [1:0] ALUSrcB, ResultSrc, FaultCode;
   logic MemReq, MulStart, Fault;
   logic [3:0] StateOut;

   logic lg_IRWrite, lg_AdrSrc, lg_ALUSrcA, lg_NextPC, lg_RegW, lg_MemW;
   logic lg_Branch, lg_ALUOp, lg_MemReq, lg_MulStart, lg_Fault;
   logic [1:0] lg_ALUSrcB, lg_ResultSrc, lg_FaultCode;
   logic [3:0] lg_StateOut;

   always #5 clk = ~clk;

   mainfsm_ws #(.WAIT_TIMEOUT(4), .ILLEGAL_TRAP(1)) dut (
      .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct),
      .IsMul(IsMul), .MemReady(MemReady), .MulDone(MulDone),
      .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
      .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch),
      .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .MemReq(MemReq), .MulStart(MulStart), .Fault(Fault),
      .FaultCode(FaultCode), .StateOut(StateOut)
   );

   mainfsm_ws #(.WAIT_TIMEOUT(0), .ILLEGAL_TRAP(0)) dut_lg (
      .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct),
      .IsMul(IsMul), .MemReady(MemReady), .MulDone(MulDone),
      .IRWrite(lg_IRWrite), .AdrSrc(lg_AdrSrc), .ALUSrcA(lg_ALUSrcA),
      .NextPC(lg_NextPC), .RegW(lg_RegW), .MemW(lg_MemW),
      .Branch(lg_Branch), .ALUOp(lg_ALUOp), .ALUSrcB(lg_ALUSrcB),
      .ResultSrc(lg_ResultSrc), .MemReq(lg_MemReq),
      .MulStart(lg_MulStart), .Fault(lg_Fault),
      .FaultCode(lg_FaultCode), .StateOut(lg_StateOut)
   );

   typedef struct {
      logic [3:0]  st;
      logic [11:0] cw;
      logic        req;
      logic        ms;
      logic        flt;
      logic [1:0]  fc;
   } exp_t;

   exp_t sbq[$];
   int errs = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] cw_of(input logic [3:0] s);
      case (s)
         4'd0:    return 12'b1_0_0_0_1_0_10_1_10_0;
         4'd2:    return 12'b0_0_0_0_0_0_10_0_01_0;
         4'd3:    return 12'b0_0_0_0_0_1_00_0_01_0;
         4'd4:    return 12'b0_0_0_1_0_1_01_0_01_0;
         4'd5:    return 12'b0_0_1_0_0_1_00_0_01_0;
         4'd6:    return 12'b0_0_0_0_0_0_10_0_00_1;
         4'd7:    return 12'b0_0_0_0_0_0_10_0_01_1;
         4'd8:    return 12'b0_0_0_1_0_0_00_0_01_0;
         4'd9:    return 12'b0_1_0_0_0_0_10_0_01_0;
         default: return 12'b0_0_0_0_0_0_10_1_10_0;
      endcase
   endfunction

   // Drive one cycle of inputs, queue the expected outputs, compare, advance
   task automatic cyc(input string tag, input logic [1:0] op,
                      input logic [5:0] fn, input logic ism,
                      input logic rdy, input logic md,
                      input logic [3:0] es, input logic ems,
                      input logic ef, input logic [1:0] ec);
      exp_t e, o;
      logic [11:0] c;
      logic ws;
      Op = op; Funct = fn; IsMul = ism; MemReady = rdy; MulDone = md;
      ws = (es == 4'd0) || (es == 4'd3) || (es == 4'd5);
      c = cw_of(es);
      if ((ws && !rdy) || !reset_n) c = c & 12'h07F;
      e = '{es, c, ws && reset_n, ems, ef, ec};
      sbq.push_back(e);
      #1;
      o = sbq.pop_front();
      check({tag, ".state"}, 32'(StateOut), 32'(o.st));
      check({tag, ".ctrl"}, 32'({NextPC, Branch, MemW, RegW, IRWrite,
            AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}), 32'(o.cw));
      check({tag, ".memreq"}, 32'(MemReq), 32'(o.req));
      check({tag, ".mulstart"}, 32'(MulStart), 32'(o.ms));
      check({tag, ".fault"}, 32'(Fault), 32'(o.flt));
      check({tag, ".code"}, 32'(FaultCode), 32'(o.fc));
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cyc("rst", 2'b00, 6'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00);
      reset_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      Op = 2'b00; Funct = 6'd0; IsMul = 1'b0;
      MemReady = 1'b1; MulDone = 1'b0;
      @(negedge clk);
      do_reset();

      // LDR with MemReady tied high: legacy latency
      cyc("ldr", 2'b01, 6'b011001, 0, 1, 0, 4'd0, 0, 0, 2'b00);
      cyc("ldr", 2'b01, 6'b011001, 0, 1, 0, 4'd1, 0, 0, 2'b00);
      cyc("ldr", 2'b01, 6'b011001, 0, 1, 0, 4'd2, 0, 0, 2'b00);
      cyc("ldr", 2'b01, 6'b011001, 0, 1, 0, 4'd3, 0, 0, 2'b00);
      cyc("ldr", 2'b01, 6'b011001, 0, 1, 0, 4'd4, 0, 0, 2'b00);

      // Fetch held off three cycles, then EXECR
      for (int i = 0; i < 3; i++)
         cyc("fwait", 2'b00, 6'd0, 0, 0, 0, 4'd0, 0, 0, 2'b00);
      cyc("fwait", 2'b00, 6'd0, 0, 1, 0, 4'd0, 0, 0, 2'b00);
      cyc("execr", 2'b00, 6'd0, 0, 1, 0, 4'd1, 0, 0, 2'b00);
      cyc("execr", 2'b00, 6'd0, 0, 1, 0, 4'd6, 0, 0, 2'b00);
      cyc("execr", 2'b00, 6'd0, 0, 1, 0, 4'd8, 0, 0, 2'b00);

      cyc("execi", 2'b00, 6'b100000, 0, 1, 0, 4'd0, 0, 0, 2'b00);
      cyc("execi", 2'b00, 6'b100000, 0, 1, 0, 4'd1, 0, 0, 2'b00);
      cyc("execi", 2'b00, 6'b100000, 0, 1, 0, 4'd7, 0, 0, 2'b00);
      cyc("execi", 2'b00, 6'b100000, 0, 1, 0, 4'd8, 0, 0, 2'b00);

      cyc("br", 2'b10, 6'd0, 0, 1, 0, 4'd0, 0, 0, 2'b00);
      cyc("br", 2'b10, 6'd0, 0, 1, 0, 4'd1, 0, 0, 2'b00);
      cyc("br", 2'b10, 6'd0, 0, 1, 0, 4'd9, 0, 0, 2'b00);

      // STR with two wait cycles in MEMWR
      cyc("str", 2'b01, 6'd0, 0, 1, 0, 4'd0, 0, 0, 2'b00);
      cyc("str", 2'b01, 6'd0, 0, 1, 0, 4'd1, 0, 0, 2'b00);
      cyc("str", 2'b01, 6'd0, 0, 1, 0, 4'd2, 0, 0, 2'b00);
      cyc("str", 2'b01, 6'd0, 0, 0, 0, 4'd5, 0, 0, 2'b00);
      cyc("str", 2'b01, 6'd0, 0, 0, 0, 4'd5, 0, 0, 2'b00);
      cyc("str", 2'b01, 6'd0, 0, 1, 0, 4'd5, 0, 0, 2'b00);

      cyc("mul", 2'b00, 6'd0, 1, 1, 0, 4'd0, 0, 0, 2'b00);
      cyc("mul", 2'b00, 6'd0, 1, 1, 0, 4'd1, 0, 0, 2'b00);
`ifdef MAINFSM_MUL_EN
      cyc("mul", 2'b00, 6'd0, 1, 1, 0, 4'd10, 1, 0, 2'b00);
      for (int i = 0; i < 5; i++)
         cyc("mul", 2'b00, 6'd0, 1, 1, 0, 4'd10, 0, 0, 2'b00);
      cyc("mul", 2'b00, 6'd0, 1, 1, 1, 4'd10, 0, 0, 2'b00);
      cyc("mul", 2'b00, 6'd0, 1, 1, 0, 4'd8, 0, 0, 2'b00);
      cyc("mul0", 2'b00, 6'd0, 1, 1, 0, 4'd0, 0, 0, 2'b00);
      cyc("mul0", 2'b00, 6'd0, 1, 1, 0, 4'd1, 0, 0, 2'b00);
      cyc("mul0", 2'b00, 6'd0, 1, 1, 1, 4'd10, 1, 0, 2'b00);
      cyc("mul0", 2'b00, 6'd0, 1, 1, 0, 4'd8, 0, 0, 2'b00);
`else
      cyc("mul", 2'b00, 6'd0, 1, 1, 1, 4'd6, 0, 0, 2'b00);
      cyc("mul", 2'b00, 6'd0, 1, 1, 0, 4'd8, 0, 0, 2'b00);
`endif

      // MEMWR stuck: five wait cycles then timeout fault
      cyc("to", 2'b01, 6'd0, 0, 1, 0, 4'd0, 0, 0, 2'b00);
      cyc("to", 2'b01, 6'd0, 0, 1, 0, 4'd1, 0, 0, 2'b00);
      cyc("to", 2'b01, 6'd0, 0, 1, 0, 4'd2, 0, 0, 2'b00);
      for (int i = 0; i < 5; i++)
         cyc("to", 2'b01, 6'd0, 0, 0, 0, 4'd5, 0, 0, 2'b00);
      check("lg.noto.state", 32'(lg_StateOut), 32'd5);
      check("lg.noto.fault", 32'(lg_Fault), 32'd0);
      for (int i = 0; i < 3; i++)
         cyc("to.hold", 2'b01, 6'd0, 0, 1, 0, 4'd15, 0, 1, 2'b01);

      do_reset();

      // Async reset while a store strobe is live
      cyc("rmw", 2'b01, 6'd0, 0, 1, 0, 4'd0, 0, 0, 2'b00);
      cyc("rmw", 2'b01, 6'd0, 0, 1, 0, 4'd1, 0, 0, 2'b00);
      cyc("rmw", 2'b01, 6'd0, 0, 1, 0, 4'd2, 0, 0, 2'b00);
      MemReady = 1'b1;
      #1;
      check("rmw.memw.pre", 32'(MemW), 32'd1);
      check("rmw.memreq.pre", 32'(MemReq), 32'd1);
      reset_n = 1'b0;
      #1;
      check("rmw.memw", 32'(MemW), 32'd0);
      check("rmw.memreq", 32'(MemReq), 32'd0);
      check("rmw.state", 32'(StateOut), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      cyc("rmw.post", 2'b01, 6'd0, 0, 1, 0, 4'd0, 0, 0, 2'b00);

      // Illegal Op: trap in main instance, legacy instance refetches
      cyc("ill", 2'b11, 6'd0, 0, 1, 0, 4'd1, 0, 0, 2'b00);
      check("lg.ill.state", 32'(lg_StateOut), 32'd0);
      check("lg.ill.fault", 32'(lg_Fault), 32'd0);
      cyc("ill", 2'b11, 6'd0, 0, 1, 0, 4'd15, 0, 1, 2'b10);
      cyc("ill", 2'b00, 6'd0, 0, 1, 0, 4'd15, 0, 1, 2'b10);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
